data_memory_param: RTL and testbench

Parametrised single-port synchronous data memory for the micro datapath. It replaces the fixed 16x4 data memory with configurable width and depth, a selectable read-during-write mode, and a hardware clear sequencer. The sequencer zeroes every location after reset or on request. It sits between the datapath address/data buses and the register file load path.

---
 rtl/data_memory_param.sv | 105 ++++++++++
 tb/tb_data_memory_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_param.sv
`default_nettype none
// data_memory_param: single-port synchronous data memory with a hardware clear sequencer.
// Rev 1.0
module data_memory_param #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter bit RDW_MODE   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  busy,
  output logic                  wr_ack
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    wr_ack_q, wr_ack_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign rd_data = mem_q[address];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    q_d        = q_q;
    wr_ack_d   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = address;
    mem_wdata  = data;
    case (state_q)
      S_CLEAR: begin
        // The sequencer owns the write port; clr_addr wraps to 0 after the last location.
        mem_we     = 1'b1;
        mem_addr   = clr_addr_q;
        mem_wdata  = '0;
        q_d        = '0;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          q_d        = '0;
        end else begin
          mem_we   = wren;
          wr_ack_d = wren;
          q_d      = (wren && RDW_MODE) ? data : rd_data;
        end
      end
      default: begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      q_q        <= '0;
      wr_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      q_q        <= q_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  // Array has no reset; the sequencer zeroes it after every reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign q      = q_q;
  assign busy   = (state_q == S_CLEAR);
  assign wr_ack = wr_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_param.sv
`default_nettype none
// tb_data_memory_param: directed bench with a behavioural memory model for three configurations.
// Rev 1.0
module tb_data_memory_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [3:0] addr, din;
  logic       wren, clr;
  logic [5:0] addr2;
  logic [7:0] din2;
  logic       wren2, clr2;

  logic [3:0] q0, q1;
  logic [7:0] q2;
  logic       busy0, busy1, busy2, ack0, ack1, ack2;

  data_memory_param #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .RDW_MODE(1'b1)) u0 (
    .clock(clock), .reset(reset), .address(addr), .data(din), .wren(wren),
    .clear_req(clr), .q(q0), .busy(busy0), .wr_ack(ack0));

  data_memory_param #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .RDW_MODE(1'b0)) u1 (
    .clock(clock), .reset(reset), .address(addr), .data(din), .wren(wren),
    .clear_req(clr), .q(q1), .busy(busy1), .wr_ack(ack1));

  data_memory_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(1'b1)) u2 (
    .clock(clock), .reset(reset), .address(addr2), .data(din2), .wren(wren2),
    .clear_req(clr2), .q(q2), .busy(busy2), .wr_ack(ack2));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: memory contents, remaining clear cycles, expected q / wr_ack per instance.
  logic [31:0] mm [3][1024];
  int          clr_left [3];
  logic [31:0] eq [3];
  logic        eack [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int depth, input bit rdw, input logic [31:0] wmask,
                            input logic [31:0] a, input logic [31:0] d, input logic we,
                            input logic cr);
    logic [31:0] ai, di, old;
    ai = a & 32'(depth - 1);
    di = d & wmask;
    if (reset || (clr_left[k] == 0 && cr)) begin
      clr_left[k] = depth;
      eq[k]       = '0;
      eack[k]     = 1'b0;
      for (int i = 0; i < 1024; i++) mm[k][i] = '0;
    end else if (clr_left[k] > 0) begin
      clr_left[k]--;
      eq[k]   = '0;
      eack[k] = 1'b0;
    end else begin
      old = mm[k][ai];
      if (we) mm[k][ai] = di;
      eack[k] = we;
      eq[k]   = (we && rdw) ? di : old;
    end
  endtask

  always @(posedge clock) begin
    model_step(0, 16, 1'b1, 32'hF,  32'(addr),  32'(din),  wren,  clr);
    model_step(1, 16, 1'b0, 32'hF,  32'(addr),  32'(din),  wren,  clr);
    model_step(2, 64, 1'b1, 32'hFF, 32'(addr2), 32'(din2), wren2, clr2);
  end

  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      chk("m_q0",    32'(q0),    eq[0]);
      chk("m_busy0", 32'(busy0), 32'(clr_left[0] > 0));
      chk("m_ack0",  32'(ack0),  32'(eack[0]));
      chk("m_q1",    32'(q1),    eq[1]);
      chk("m_busy1", 32'(busy1), 32'(clr_left[1] > 0));
      chk("m_ack1",  32'(ack1),  32'(eack[1]));
      chk("m_q2",    32'(q2),    eq[2]);
      chk("m_busy2", 32'(busy2), 32'(clr_left[2] > 0));
      chk("m_ack2",  32'(ack2),  32'(eack[2]));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #3;
  endtask

  initial begin
    int n, n0, n2;
    reset = 1'b1;
    addr = '0; din = '0; wren = 1'b0; clr = 1'b0;
    addr2 = '0; din2 = '0; wren2 = 1'b0; clr2 = 1'b0;

    // Reset for two cycles, then busy must last exactly 16 edges.
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_q",    32'(q0),    32'd0);
    chk("rst_ack",  32'(ack0),  32'd0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      n++;
      if (!busy0) break;
    end
    chk("t1_busy_edges", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      cyc();
      chk("t1_read_zero", 32'(q0), 32'd0);
    end

    // Write without and then with wren.
    addr = 4'd0; din = 4'hA; wren = 1'b0;
    cyc();
    chk("t2_nowr_q",   32'(q0),   32'd0);
    chk("t2_nowr_ack", 32'(ack0), 32'd0);
    wren = 1'b1;
    cyc();
    chk("t2_wr_q",   32'(q0),   32'hA);
    chk("t2_wr_ack", 32'(ack0), 32'd1);
    wren = 1'b0;
    cyc();
    chk("t2_ack_drop", 32'(ack0), 32'd0);

    // Fill and read back.
    wren = 1'b1;
    addr = 4'd0; din = 4'hA; cyc();
    addr = 4'd1; din = 4'hB; cyc();
    chk("t3_ack_b2b", 32'(ack0), 32'd1);
    addr = 4'd5; din = 4'hF; cyc();
    chk("t3_ack_b2b", 32'(ack0), 32'd1);
    wren = 1'b0;
    addr = 4'd0; cyc(); chk("t3_rd0", 32'(q0), 32'hA);
    addr = 4'd1; cyc(); chk("t3_rd1", 32'(q0), 32'hB);
    addr = 4'd5; cyc(); chk("t3_rd5", 32'(q0), 32'hF);
    addr = 4'd2; cyc(); chk("t3_rd2", 32'(q0), 32'h0);

    // Read-during-write on both RDW modes.
    wren = 1'b1; addr = 4'd3; din = 4'h6; cyc();
    din = 4'h9; cyc();
    chk("t4_rdw0_old", 32'(q1), 32'h6);
    chk("t4_rdw1_new", 32'(q0), 32'h9);
    wren = 1'b0; cyc();
    chk("t4_rdw0_rd", 32'(q1), 32'h9);

    // clear_req beats a simultaneous write; a repeated request mid-clear is ignored.
    addr = 4'd7; din = 4'hC; wren = 1'b1; clr = 1'b1;
    cyc();
    chk("t5_busy",   32'(busy0), 32'd1);
    chk("t5_no_ack", 32'(ack0),  32'd0);
    wren = 1'b0; clr = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      n++;
      if (n == 3) clr = 1'b1;
      if (n == 4) clr = 1'b0;
      if (!busy0) break;
    end
    chk("t5_busy_edges", 32'(n), 32'd16);
    addr = 4'd0; cyc(); chk("t5_rd0", 32'(q0), 32'h0);
    addr = 4'd1; cyc(); chk("t5_rd1", 32'(q0), 32'h0);
    addr = 4'd5; cyc(); chk("t5_rd5", 32'(q0), 32'h0);
    addr = 4'd7; cyc(); chk("t5_rd7", 32'(q0), 32'h0);

    // Reset at clear cycle 5 restarts the full sequence; writes during busy are dropped.
    clr = 1'b1; cyc(); clr = 1'b0;
    repeat (5) cyc();
    chk("t6_busy_pre", 32'(busy0), 32'd1);
    wren = 1'b1; addr = 4'd2; din = 4'h3;
    reset = 1'b1;
    cyc();
    chk("t6_busy_rst",  32'(busy0), 32'd1);
    chk("t6_busy2_rst", 32'(busy2), 32'd1);
    reset = 1'b0;
    n = 0; n0 = 0; n2 = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n++;
      if (n == 10) wren = 1'b0;
      if (!busy0 && n0 == 0) n0 = n;
      if (!busy2) begin
        n2 = n;
        break;
      end
    end
    chk("t6_busy_edges",  32'(n0), 32'd16);
    chk("t6_busy2_edges", 32'(n2), 32'd64);
    addr = 4'd2; cyc();
    chk("t6_dropped", 32'(q0), 32'h0);

    addr2 = 6'd63; din2 = 8'hA5; wren2 = 1'b1; cyc();
    chk("t6_w_q2",   32'(q2),   32'hA5);
    chk("t6_w_ack2", 32'(ack2), 32'd1);
    wren2 = 1'b0; cyc();
    chk("t6_r_q2",   32'(q2),   32'hA5);
    chk("t6_r_ack2", 32'(ack2), 32'd0);
    addr2 = 6'd62; cyc();
    chk("t6_r62", 32'(q2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
